// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the host-link UART stages.
//   BAUD_COUNT_115200 : clocks per bit at 100 MHz / 115200 baud
//   DATA_BITS, STOP_BITS : frame shape (8N1), common to transmit and receive
//   ST_* / rx_state_t    : one-hot receiver state encoding
package uart_pkg;

    localparam int BAUD_COUNT_115200 = 868;
    localparam int DATA_BITS         = 8;
    localparam int STOP_BITS         = 1;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_START = 5'b00010;
    localparam logic [4:0] ST_DATA  = 5'b00100;
    localparam logic [4:0] ST_STOP  = 5'b01000;
    localparam logic [4:0] ST_BREAK = 5'b10000;

    typedef enum logic [4:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP,
        S_BREAK = ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for asynchronous board inputs.
//   clk   : destination clock
//   rst_n : async active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output (2-cycle latency)
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with a valid/ack holding register.
//   CLK100MHZ   : clock
//   reset_n     : async active-low reset
//   UART_TXD_IN : serial line from host (idles high)
//   data/valid  : received byte, held until ack
//   ack         : consumer takes the byte
//   frame_err   : 1-cycle pulse when the stop bit samples low
//   overrun     : sticky, a completed byte was dropped while valid was set
module uart_recv
    import uart_pkg::*;
#(
    parameter int BAUD_COUNT = BAUD_COUNT_115200
) (
    input  logic       CLK100MHZ,
    input  logic       reset_n,
    input  logic       UART_TXD_IN,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF_COUNT = BAUD_COUNT / 2;
    localparam int CW         = $clog2(BAUD_COUNT);
    localparam int IW         = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_COUNT - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] sh;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (CLK100MHZ),
        .rst_n (reset_n),
        .d     (UART_TXD_IN),
        .q     (rx_s)
    );

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Handshake first; a byte completing this cycle overrides the clear below.
            if (ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        // High at mid-start-bit means a glitch, not a frame.
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BAUD_LAST) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) state <= S_STOP;
                        else                 idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BAUD_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Leave mid-stop-bit so a back-to-back start edge is caught.
                            state <= S_IDLE;
                            if (!valid || ack) begin
                                data  <= sh;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high, so a stuck-low line
                    // does not retrigger frames.
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_recv.md
# uart_recv

Serial-to-byte UART receiver for the Nexys4DDR host link: 8 data bits, no parity, 1 stop bit, LSB first, 115200 baud from the 100 MHz board clock. It is the counterpart of the transmit stage. It deserialises bytes the host sends on the USB-UART line and hands each byte to the accelerator's command and weight-loading logic over a valid/ack holding register.

## Interface
- `BAUD_COUNT`, default 868: clock cycles per bit (100e6/115200). `HALF_COUNT = BAUD_COUNT/2` is derived, not overridable.
- `CLK100MHZ` in 1: sole clock, rising edge.
- `reset_n` in 1: reset; one clock, asynchronous assert, active-low.
- `UART_TXD_IN` in 1: serial line from the host; asynchronous, idles high.
- `data` out 8: received byte; stable while `valid`=1.
- `valid` out 1: byte available; held until acknowledged.
- `ack` in 1: consumer takes the byte; sampled on a clock edge.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `overrun` out 1: sticky; a completed byte was dropped because `valid` was still set.

## Operation
- Input path: 2-flop synchroniser produces `rx_s`. All decisions use `rx_s`. Synchroniser flops reset to 1.
- One-hot FSM: IDLE, START, DATA, STOP, BREAK. Bit counter `cnt` has width $clog2(BAUD_COUNT). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- IDLE: when `rx_s`=0, go to START with `cnt`=0.
- START: when `cnt`=HALF_COUNT-1, sample `rx_s`.
  - 0: go to DATA with `cnt`=0 and `idx`=0.
  - 1: false start; go to IDLE.
- DATA: when `cnt`=BAUD_COUNT-1, shift in `sh <= {rx_s, sh[7:1]}` and set `cnt`=0. After `idx`=7 is sampled, go to STOP; otherwise increment `idx`.
- STOP: when `cnt`=BAUD_COUNT-1, sample `rx_s`.
  - 1, and `valid`=0 or `ack`=1 this cycle: load `data <= sh`, set `valid`=1, go to IDLE.
  - 1, and `valid`=1 with `ack`=0: keep the old `data` and `valid`, drop the new byte, set `overrun`=1, go to IDLE.
  - 0: pulse `frame_err` for one cycle, discard the byte, go to BREAK.
- BREAK: wait for `rx_s`=1, then go to IDLE. This prevents retriggering on a held-low line.
- Handshake: `ack` while `valid`=1 clears `valid` on the next edge, unless a new byte loads in the same cycle, in which case `valid` stays 1 with the new `data`. `ack` while `valid`=0 is ignored. `ack` also clears `overrun`.
- Reset values:
  - `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0.
  - FSM=IDLE, `cnt`=0, `idx`=0, `sh`=0.
- Reset mid-frame aborts the frame and emits no partial byte. After release, the receiver waits in IDLE for the next falling edge.

## Timing
- Sample point is mid-bit: the start bit at HALF_COUNT. Each later bit is sampled BAUD_COUNT cycles after the previous sample.
- Latency: `valid` rises 9*BAUD_COUNT + HALF_COUNT + 3 cycles after the first low clock edge at `UART_TXD_IN`. That is 2 cycles of synchroniser, 1 cycle of IDLE detect, and the registered load. The bench tolerance is ±1 cycle.
- `frame_err` has the same latency and lasts exactly 1 cycle.
- The receiver returns to IDLE about a half bit before the end of the stop bit. A back-to-back start bit is therefore detected with no lost frame.
- Tolerates roughly ±4% baud mismatch. No oversampling or majority vote.

## Structure
- Package `uart_pkg`:
  - `BAUD_COUNT_115200 = 868`.
  - One-hot state localparams for IDLE, START, DATA, STOP, BREAK.
  - Frame constants `DATA_BITS = 8` and `STOP_BITS = 1`, shared with the transmit stage.
- Sub-module `uart_sync`: 2-flop synchroniser, parameterised reset value (1 here), async active-low reset. It is reused for the other board inputs.
- FSM, counters and holding register stay flat in `uart_recv`.

## Test plan
- **Single byte:** send 0xA5 at BAUD_COUNT=868, `ack` tied low. Require `data`=0xA5, `valid`=1 at latency 868*9+434+3 ±1, `frame_err`=0, `overrun`=0.
- **Back-to-back with ack:** send 0x00, 0xFF, 0x3C with no idle gap, acking 5 cycles after each `valid`. Require 3 valid bytes in order and no `overrun`.
- **False start:** drive a 100-cycle low glitch, then idle. Require `valid` to stay 0 and the FSM to return to IDLE within HALF_COUNT+3 cycles.
- **Framing error:** send 0x55 with the stop bit low, holding low for 2000 cycles, then high, then send 0x12. Require one `frame_err` pulse, no `valid` for 0x55, and 0x12 received correctly.
- **Overrun:** send 0x11 then 0x22 with no `ack`. Require `data`=0x11, `valid`=1, `overrun`=1. Then `ack` once: `valid`=0 and `overrun`=0.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 4 of 0x9E, release, then send 0x47. Require all outputs at reset values, no partial byte, and `data`=0x47 delivered.
